// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core.
//   LOAD_*   : load-type encodings carried down the pipeline (5-7 reserved, treated as LW)
//   WDSEL_*  : GRF write-data source select (3 reserved, treated as ALU)
//   PC_RESET : text base, reset/flush value of the W-stage PC
package mips_pkg;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LBU = 3'd1;
  localparam logic [2:0] LOAD_LB  = 3'd2;
  localparam logic [2:0] LOAD_LHU = 3'd3;
  localparam logic [2:0] LOAD_LH  = 3'd4;

  localparam logic [1:0] WDSEL_ALU  = 2'd0;
  localparam logic [1:0] WDSEL_LOAD = 2'd1;
  localparam logic [1:0] WDSEL_PC8  = 2'd2;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

endpackage

// File: rtl/mw_stage_ldext_load_ext.sv
// load_ext: combinational load-data extractor.
// Ports:
//   word     in  32  raw data-memory word
//   addr     in  2   low address bits (byte offset within the word)
//   loadop   in  3   load type (mips_pkg LOAD_*)
//   data     out 32  extracted, sign/zero-extended load data
//   misalign out 1   address not aligned to the access size
// Misaligned accesses still return word-aligned data: LW ignores addr,
// halves use addr[1] only.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  loadop,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    byte_sel = word[7:0];
    unique case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (loadop)
      LOAD_LBU: data = {24'd0, byte_sel};
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LHU: begin
        data     = {16'd0, half_sel};
        misalign = addr[0];
      end
      LOAD_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = addr[0];
      end
      // LW and the reserved encodings pass the word through.
      default: begin
        data     = word;
        misalign = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mw_stage_ldext.sv
// mw_stage_ldext: MEM->WB pipeline register plus writeback data path.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   en                capture enable (0 = hold/stall)
//   clr               synchronous bubble insert, priority over en
//   alu_M, dm_M, pc_M ALU result/address, raw DM word, PC from M
//   rd_M, regwrite_M  destination register and its write enable
//   loadop_M, wdsel_M load type and write-data source
//   pc_W, rd_W        registered PC and destination
//   regwrite_W        effective GRF write enable ($0 never written)
//   wd_W              GRF write data, combinational from W registers
//   misalign_W        load address misaligned for its size (LOAD select only)
module mw_stage_ldext
  import mips_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] alu_M,
  input  logic [DW-1:0] dm_M,
  input  logic [DW-1:0] pc_M,
  input  logic [4:0]    rd_M,
  input  logic          regwrite_M,
  input  logic [2:0]    loadop_M,
  input  logic [1:0]    wdsel_M,
  output logic [DW-1:0] pc_W,
  output logic [4:0]    rd_W,
  output logic          regwrite_W,
  output logic [DW-1:0] wd_W,
  output logic          misalign_W
);

  logic [DW-1:0] alu_r;
  logic [DW-1:0] dm_r;
  logic [DW-1:0] pc_r;
  logic [4:0]    rd_r;
  logic          regwrite_r;
  logic [2:0]    loadop_r;
  logic [1:0]    wdsel_r;

  logic [DW-1:0] load_data;
  logic          load_misalign;

  // Reset and bubble share one path: a bubble must look exactly like reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset || clr) begin
      alu_r      <= '0;
      dm_r       <= '0;
      pc_r       <= PC_RESET;
      rd_r       <= '0;
      regwrite_r <= 1'b0;
      loadop_r   <= LOAD_LW;
      wdsel_r    <= WDSEL_ALU;
    end else if (en) begin
      alu_r      <= alu_M;
      dm_r       <= dm_M;
      pc_r       <= pc_M;
      rd_r       <= rd_M;
      regwrite_r <= regwrite_M;
      loadop_r   <= loadop_M;
      wdsel_r    <= wdsel_M;
    end
  end

  load_ext u_load_ext (
    .word     (dm_r),
    .addr     (alu_r[1:0]),
    .loadop   (loadop_r),
    .data     (load_data),
    .misalign (load_misalign)
  );

  always_comb begin
    wd_W = alu_r;
    unique case (wdsel_r)
      WDSEL_LOAD: wd_W = load_data;
      WDSEL_PC8:  wd_W = pc_r + DW'(8);
      default:    wd_W = alu_r;
    endcase
  end

  assign pc_W       = pc_r;
  assign rd_W       = rd_r;
  assign regwrite_W = regwrite_r && (rd_r != 5'd0);
  assign misalign_W = load_misalign && (wdsel_r == WDSEL_LOAD);

endmodule

// File: tb/tb_mw_stage_ldext.sv
// Directed testbench for mw_stage_ldext with hand-computed expectations.
module tb_mw_stage_ldext;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] alu_M, dm_M, pc_M;
  logic [4:0]  rd_M;
  logic        regwrite_M;
  logic [2:0]  loadop_M;
  logic [1:0]  wdsel_M;
  logic [31:0] pc_W, wd_W;
  logic [4:0]  rd_W;
  logic        regwrite_W, misalign_W;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mw_stage_ldext dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .alu_M      (alu_M),
    .dm_M       (dm_M),
    .pc_M       (pc_M),
    .rd_M       (rd_M),
    .regwrite_M (regwrite_M),
    .loadop_M   (loadop_M),
    .wdsel_M    (wdsel_M),
    .pc_W       (pc_W),
    .rd_W       (rd_W),
    .regwrite_W (regwrite_W),
    .wd_W       (wd_W),
    .misalign_W (misalign_W)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_m(input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic rw, input logic [2:0] lop,
                       input logic [1:0] ws);
    alu_M = alu; dm_M = dm; pc_M = pc; rd_M = rd;
    regwrite_M = rw; loadop_M = lop; wdsel_M = ws;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string tag, input logic [31:0] wd, input logic mis,
                         input logic rw, input logic [4:0] rd, input logic [31:0] pc);
    check({tag, ".wd"},       wd_W,       wd);
    check({tag, ".misalign"}, 32'(misalign_W), 32'(mis));
    check({tag, ".regwrite"}, 32'(regwrite_W), 32'(rw));
    check({tag, ".rd"},       32'(rd_W),  32'(rd));
    check({tag, ".pc"},       pc_W,       pc);
  endtask

  localparam logic [31:0] DM = 32'h8899_AABB;

  initial begin
    reset = 1'b1; en = 1'b1; clr = 1'b0;
    set_m(32'h0000_1234, DM, 32'h0000_0400, 5'd9, 1'b1, 3'd0, 2'd1);
    tick(); tick();
    check_w("reset", 32'h0, 1'b0, 1'b0, 5'd0, 32'h0000_3000);
    reset = 1'b0;

    // Byte/half extraction, sign vs zero extension, misalign flagging.
    set_m(32'h0000_1001, DM, 32'h0000_0100, 5'd8, 1'b1, 3'd2, 2'd1); tick();
    check_w("lb_off1", 32'hFFFF_FFAA, 1'b0, 1'b1, 5'd8, 32'h0000_0100);
    set_m(32'h0000_1001, DM, 32'h0000_0104, 5'd8, 1'b1, 3'd1, 2'd1); tick();
    check_w("lbu_off1", 32'h0000_00AA, 1'b0, 1'b1, 5'd8, 32'h0000_0104);
    set_m(32'h0000_1003, DM, 32'h0000_0108, 5'd8, 1'b1, 3'd2, 2'd1); tick();
    check_w("lb_off3", 32'hFFFF_FF88, 1'b0, 1'b1, 5'd8, 32'h0000_0108);
    set_m(32'h0000_1000, DM, 32'h0000_010C, 5'd8, 1'b1, 3'd1, 2'd1); tick();
    check_w("lbu_off0", 32'h0000_00BB, 1'b0, 1'b1, 5'd8, 32'h0000_010C);
    set_m(32'h0000_1002, DM, 32'h0000_0110, 5'd3, 1'b1, 3'd4, 2'd1); tick();
    check_w("lh_off2", 32'hFFFF_8899, 1'b0, 1'b1, 5'd3, 32'h0000_0110);
    set_m(32'h0000_1003, DM, 32'h0000_0114, 5'd3, 1'b1, 3'd4, 2'd1); tick();
    check_w("lh_off3", 32'hFFFF_8899, 1'b1, 1'b1, 5'd3, 32'h0000_0114);
    set_m(32'h0000_1000, DM, 32'h0000_0118, 5'd3, 1'b1, 3'd3, 2'd1); tick();
    check_w("lhu_off0", 32'h0000_AABB, 1'b0, 1'b1, 5'd3, 32'h0000_0118);
    set_m(32'h0000_1001, DM, 32'h0000_011C, 5'd3, 1'b1, 3'd3, 2'd1); tick();
    check_w("lhu_off1", 32'h0000_AABB, 1'b1, 1'b1, 5'd3, 32'h0000_011C);
    set_m(32'h0000_1002, DM, 32'h0000_0120, 5'd4, 1'b1, 3'd0, 2'd1); tick();
    check_w("lw_off2", DM, 1'b1, 1'b1, 5'd4, 32'h0000_0120);
    set_m(32'h0000_1000, DM, 32'h0000_0124, 5'd4, 1'b1, 3'd6, 2'd1); tick();
    check_w("rsvd_lop", DM, 1'b0, 1'b1, 5'd4, 32'h0000_0124);

    // Misalign only reported when writing back load data.
    set_m(32'h0000_1002, DM, 32'h0000_0128, 5'd4, 1'b1, 3'd0, 2'd0); tick();
    check_w("alu_sel", 32'h0000_1002, 1'b0, 1'b1, 5'd4, 32'h0000_0128);
    set_m(32'hCAFE_0001, DM, 32'h0000_012C, 5'd0, 1'b1, 3'd0, 2'd0); tick();
    check_w("rd_zero", 32'hCAFE_0001, 1'b0, 1'b0, 5'd0, 32'h0000_012C);
    set_m(32'h0000_0001, DM, 32'hFFFF_FFFC, 5'd31, 1'b1, 3'd0, 2'd2); tick();
    check_w("pc8_wrap", 32'h0000_0004, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC);
    set_m(32'h1357_9BDF, DM, 32'h0000_0130, 5'd7, 1'b0, 3'd0, 2'd3); tick();
    check_w("wdsel3", 32'h1357_9BDF, 1'b0, 1'b0, 5'd7, 32'h0000_0130);

    // Stall: capture, then hold for 3 cycles while inputs change.
    set_m(32'h0000_5678, DM, 32'h0000_0400, 5'd5, 1'b1, 3'd0, 2'd0); tick();
    check_w("capture", 32'h0000_5678, 1'b0, 1'b1, 5'd5, 32'h0000_0400);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_m(32'h0000_1003 + 32'(i), DM, 32'h0000_0500 + 32'(4 * i), 5'd10 + 5'(i), 1'b1, 3'd2, 2'd1);
      tick();
      check_w($sformatf("hold%0d", i), 32'h0000_5678, 1'b0, 1'b1, 5'd5, 32'h0000_0400);
    end

    // Bubble wins over enable.
    en = 1'b1; clr = 1'b1;
    set_m(32'h0000_9999, DM, 32'h0000_0600, 5'd6, 1'b1, 3'd0, 2'd0); tick();
    check_w("bubble", 32'h0, 1'b0, 1'b0, 5'd0, 32'h0000_3000);
    clr = 1'b0;

    // Reset while stalled clears held state.
    set_m(32'h0000_4444, DM, 32'h0000_0700, 5'd12, 1'b1, 3'd0, 2'd0); tick();
    check_w("pre_rst", 32'h0000_4444, 1'b0, 1'b1, 5'd12, 32'h0000_0700);
    en = 1'b0; reset = 1'b1; tick();
    check_w("rst_stall", 32'h0, 1'b0, 1'b0, 5'd0, 32'h0000_3000);
    reset = 1'b0; tick();
    check_w("post_rst_hold", 32'h0, 1'b0, 1'b0, 5'd0, 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
